// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing the L2-to-main-memory line port between the
// instruction-side (0) and data-side (1) L2 caches.
module l2_mem_arbiter #(
    parameter int          TNUM    = 22,
    parameter int          INUM    = 26 - TNUM,
    parameter int          LINE_W  = 512,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              read_req0,
    input  logic              read_req1,
    input  logic              write_req0,
    input  logic              write_req1,
    input  logic [TNUM-1:0]   tag0,
    input  logic [TNUM-1:0]   tag1,
    input  logic [TNUM-1:0]   write_tag0,
    input  logic [TNUM-1:0]   write_tag1,
    input  logic [INUM-1:0]   index0,
    input  logic [INUM-1:0]   index1,
    input  logic [LINE_W-1:0] write_data0,
    input  logic [LINE_W-1:0] write_data1,
    output logic              ready0,
    output logic              ready1,
    output logic [LINE_W-1:0] read_data,
    output logic              err,
    output logic              read_L2_MEM,
    output logic              write_L2_MEM,
    output logic [TNUM-1:0]   tag_L2_MEM,
    output logic [TNUM-1:0]   write_tag_L2_MEM,
    output logic [INUM-1:0]   index_L2_MEM,
    output logic [LINE_W-1:0] write_data_L2_MEM,
    input  logic              ready_MEM_L2,
    input  logic [LINE_W-1:0] read_data_MEM_L2
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

    state_t              state, state_nxt;
    logic                last_grant, last_grant_nxt;
    logic                gnt, gnt_nxt;
    logic [15:0]         cnt, cnt_nxt;
    logic                act0, act1, sel;
    logic                ready0_nxt, ready1_nxt, err_nxt;
    logic                read_nxt, write_nxt;
    logic [TNUM-1:0]     tag_nxt, write_tag_nxt;
    logic [INUM-1:0]     index_nxt;
    logic [LINE_W-1:0]   write_data_nxt, read_data_nxt;

    assign act0 = read_req0 | write_req0;
    assign act1 = read_req1 | write_req1;
    // On a tie the requester that did not win last time goes next.
    assign sel  = (act0 && act1) ? ~last_grant : act1;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gnt_nxt        = gnt;
        cnt_nxt        = cnt;
        ready0_nxt     = 1'b0;
        ready1_nxt     = 1'b0;
        err_nxt        = 1'b0;
        read_nxt       = read_L2_MEM;
        write_nxt      = write_L2_MEM;
        tag_nxt        = tag_L2_MEM;
        write_tag_nxt  = write_tag_L2_MEM;
        index_nxt      = index_L2_MEM;
        write_data_nxt = write_data_L2_MEM;
        read_data_nxt  = read_data;
        case (state)
            IDLE: begin
                if (act0 || act1) begin
                    // A simultaneous read+write from one requester is a write.
                    write_nxt      = sel ? write_req1 : write_req0;
                    read_nxt       = sel ? (read_req1 & ~write_req1) : (read_req0 & ~write_req0);
                    tag_nxt        = sel ? tag1 : tag0;
                    write_tag_nxt  = sel ? write_tag1 : write_tag0;
                    index_nxt      = sel ? index1 : index0;
                    write_data_nxt = sel ? write_data1 : write_data0;
                    gnt_nxt        = sel;
                    last_grant_nxt = sel;
                    cnt_nxt        = 16'd0;
                    state_nxt      = BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                if (ready_MEM_L2) begin
                    read_data_nxt = read_data_MEM_L2;
                    read_nxt      = 1'b0;
                    write_nxt     = 1'b0;
                    ready0_nxt    = ~gnt;
                    ready1_nxt    = gnt;
                    state_nxt     = DONE;
                end else if (cnt == TO_LAST) begin
                    read_nxt   = 1'b0;
                    write_nxt  = 1'b0;
                    ready0_nxt = ~gnt;
                    ready1_nxt = gnt;
                    err_nxt    = 1'b1;
                    state_nxt  = DONE;
                end
            end
            // One dead cycle keeps the memory command low for two cycles.
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state             <= IDLE;
            last_grant        <= 1'b1;
            gnt               <= 1'b0;
            cnt               <= 16'd0;
            ready0            <= 1'b0;
            ready1            <= 1'b0;
            err               <= 1'b0;
            read_L2_MEM       <= 1'b0;
            write_L2_MEM      <= 1'b0;
            tag_L2_MEM        <= '0;
            write_tag_L2_MEM  <= '0;
            index_L2_MEM      <= '0;
            write_data_L2_MEM <= '0;
            read_data         <= '0;
        end else begin
            state             <= state_nxt;
            last_grant        <= last_grant_nxt;
            gnt               <= gnt_nxt;
            cnt               <= cnt_nxt;
            ready0            <= ready0_nxt;
            ready1            <= ready1_nxt;
            err               <= err_nxt;
            read_L2_MEM       <= read_nxt;
            write_L2_MEM      <= write_nxt;
            tag_L2_MEM        <= tag_nxt;
            write_tag_L2_MEM  <= write_tag_nxt;
            index_L2_MEM      <= index_nxt;
            write_data_L2_MEM <= write_data_nxt;
            read_data         <= read_data_nxt;
        end
    end
endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: directed scenarios then randomized traffic checked
// against a transaction-level model (winner choice, latency, timeout, data).
module tb_l2_mem_arbiter;
    localparam int          TNUM    = 22;
    localparam int          INUM    = 26 - TNUM;
    localparam int          LINE_W  = 512;
    localparam logic [15:0] TIMEOUT = 16'd48;
    localparam int          TO      = 48;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0]        rq_r, rq_w;
    logic [TNUM-1:0]   tg [2];
    logic [TNUM-1:0]   wtg [2];
    logic [INUM-1:0]   ix [2];
    logic [LINE_W-1:0] wd [2];
    logic              ready_mem;
    logic [LINE_W-1:0] mem_line;

    logic              ready0, ready1, err, read_L2_MEM, write_L2_MEM;
    logic [LINE_W-1:0] read_data, write_data_L2_MEM;
    logic [TNUM-1:0]   tag_L2_MEM, write_tag_L2_MEM;
    logic [INUM-1:0]   index_L2_MEM;

    l2_mem_arbiter #(.TNUM(TNUM), .INUM(INUM), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .read_req0(rq_r[0]), .read_req1(rq_r[1]),
        .write_req0(rq_w[0]), .write_req1(rq_w[1]),
        .tag0(tg[0]), .tag1(tg[1]),
        .write_tag0(wtg[0]), .write_tag1(wtg[1]),
        .index0(ix[0]), .index1(ix[1]),
        .write_data0(wd[0]), .write_data1(wd[1]),
        .ready0(ready0), .ready1(ready1), .read_data(read_data), .err(err),
        .read_L2_MEM(read_L2_MEM), .write_L2_MEM(write_L2_MEM),
        .tag_L2_MEM(tag_L2_MEM), .write_tag_L2_MEM(write_tag_L2_MEM),
        .index_L2_MEM(index_L2_MEM), .write_data_L2_MEM(write_data_L2_MEM),
        .ready_MEM_L2(ready_mem), .read_data_MEM_L2(mem_line)
    );

    int                n_cmp = 0;
    int                n_bad = 0;
    logic              m_last;
    logic [LINE_W-1:0] m_rd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic rand_fields(input int r);
        tg[r]  = TNUM'($urandom);
        wtg[r] = TNUM'($urandom);
        ix[r]  = INUM'($urandom);
        wd[r]  = rand_line();
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, ".rd_cmd"}, read_L2_MEM, 0);
        check({nm, ".wr_cmd"}, write_L2_MEM, 0);
        check({nm, ".ready0"}, ready0, 0);
        check({nm, ".ready1"}, ready1, 0);
        check({nm, ".err"}, err, 0);
        check({nm, ".read_data"}, read_data, m_rd);
    endtask

    // Called in an IDLE cycle with requests already set. Memory answers in the
    // m-th command cycle (0-based); m >= TIMEOUT means it never answers.
    task automatic txn(input int m, input string nm);
        int                w, last_c;
        logic              a0, a1, to_err, e_r, e_w;
        logic [TNUM-1:0]   e_tag, e_wtag;
        logic [INUM-1:0]   e_ix;
        logic [LINE_W-1:0] e_wd, ret;
        a0 = rq_r[0] | rq_w[0];
        a1 = rq_r[1] | rq_w[1];
        if (a0 && a1) w = m_last ? 0 : 1;
        else          w = a1 ? 1 : 0;
        m_last = (w == 1);
        e_w    = rq_w[w];
        e_r    = rq_r[w] & ~rq_w[w];
        e_tag  = tg[w];
        e_wtag = wtg[w];
        e_ix   = ix[w];
        e_wd   = wd[w];
        to_err = (m >= TO);
        last_c = to_err ? TO - 1 : m;
        ret    = rand_line();
        for (int c = 0; c <= last_c; c++) begin
            step();
            ready_mem = 1'b0;
            check({nm, ".rd_cmd"}, read_L2_MEM, e_r);
            check({nm, ".wr_cmd"}, write_L2_MEM, e_w);
            check({nm, ".tag"}, tag_L2_MEM, e_tag);
            check({nm, ".wtag"}, write_tag_L2_MEM, e_wtag);
            check({nm, ".index"}, index_L2_MEM, e_ix);
            check({nm, ".wdata"}, write_data_L2_MEM, e_wd);
            check({nm, ".busy_rdy"}, ready0 | ready1, 0);
            if (c == 1) begin
                rand_fields(0);
                rand_fields(1);
            end
            if (c == m) begin
                ready_mem = 1'b1;
                mem_line  = ret;
            end
        end
        step();
        ready_mem = 1'b0;
        if (!to_err) m_rd = ret;
        check({nm, ".done_rd_cmd"}, read_L2_MEM, 0);
        check({nm, ".done_wr_cmd"}, write_L2_MEM, 0);
        check({nm, ".ready0"}, ready0, w == 0);
        check({nm, ".ready1"}, ready1, w == 1);
        check({nm, ".err"}, err, to_err);
        check({nm, ".read_data"}, read_data, m_rd);
        rq_r[w] = 1'b0;
        rq_w[w] = 1'b0;
        // Stray memory completion during DONE must be ignored.
        ready_mem = 1'b1;
        mem_line  = rand_line();
        step();
        ready_mem = 1'b0;
        check_idle_outputs({nm, ".after"});
    endtask

    initial begin
        int m, k;
        rstn = 1'b0; rq_r = '0; rq_w = '0; ready_mem = 1'b0; mem_line = '0;
        for (int r = 0; r < 2; r++) rand_fields(r);
        m_last = 1'b1;
        m_rd   = '0;
        step();
        step();
        check_idle_outputs("reset");
        check("reset.tag", tag_L2_MEM, 0);
        check("reset.wdata", write_data_L2_MEM, 0);
        rstn = 1'b1;

        // Idle with no requests; a stray memory ready is ignored.
        ready_mem = 1'b1; mem_line = rand_line();
        step();
        ready_mem = 1'b0;
        step();
        check_idle_outputs("idle");

        // Simultaneous reads: 0 then 1, then again 0 then 1.
        rq_r = 2'b11;
        txn(5, "pair_a0");
        txn(3, "pair_a1");
        rq_r = 2'b11;
        txn(0, "pair_b0");
        txn(7, "pair_b1");

        // Single read, memory answers after 40 command cycles.
        rq_r[0] = 1'b1; tg[0] = 22'h10; ix[0] = 4'd3;
        txn(39, "single");

        // Read and write together from requester 1 become a write.
        rq_r[1] = 1'b1; rq_w[1] = 1'b1; wtg[1] = 22'h2A;
        txn(4, "rw1");

        // Memory never answers: timeout with err, read_data retained.
        rq_r[0] = 1'b1;
        txn(TO + 10, "timeout");
        // Answer on the very last allowed cycle wins over timeout.
        rq_w[1] = 1'b1;
        txn(TO - 1, "edge");

        // Reset in the middle of a transaction.
        rq_r[1] = 1'b1;
        step();
        step();
        rstn = 1'b0;
        step();
        m_last = 1'b1;
        m_rd   = '0;
        check_idle_outputs("midrst");
        rstn = 1'b1;
        rq_r[0] = 1'b1;
        txn(2, "post_rst");
        txn(1, "post_rst1");

        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!(rq_r[r] | rq_w[r]) && $urandom_range(0, 1) == 1) begin
                    rand_fields(r);
                    rq_r[r] = 1'($urandom);
                    rq_w[r] = 1'($urandom);
                    if (!(rq_r[r] | rq_w[r])) rq_r[r] = 1'b1;
                end
            end
            if (!(rq_r[0] | rq_w[0] | rq_r[1] | rq_w[1])) rq_r[0] = 1'b1;
            k = $urandom_range(0, 7);
            if (k == 0)      m = TO + 3;
            else if (k == 1) m = TO - 1;
            else             m = $urandom_range(0, 20);
            txn(m, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
